// File: rtl/game_ctrl.sv
// game_ctrl: tic-tac-toe referee and board keeper; O moves arrive from the user I/O block, X from the FPGA move engine.
// Build macro FPGA_FIRST_EN: when defined, the engine (X) moves first after reset.
module game_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_move,
    input  logic        i_validmove_stb,
    input  logic        i_busy,
    output logic        o_needinput,
    output logic [17:0] o_board,
    output logic [1:0]  o_result,
    output logic        o_isdraw,
    output logic        o_result_stb,
    output logic        o_think_stb,
    input  logic [3:0]  i_fpga_move,
    input  logic        i_fpga_move_stb,
    output logic        o_gameover
);

    localparam logic [2:0] WAIT_USER = 3'd0;
    localparam logic [2:0] CHK_USER  = 3'd1;
    localparam logic [2:0] EVAL      = 3'd2;
    localparam logic [2:0] THINK     = 3'd3;
    localparam logic [2:0] CHK_FPGA  = 3'd4;
    localparam logic [2:0] REPORT    = 3'd5;
    localparam logic [2:0] OVER      = 3'd6;

    localparam logic [1:0] CELL_O   = 2'b01;
    localparam logic [1:0] CELL_X   = 2'b10;
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_XWIN = 2'd1;
    localparam logic [1:0] RES_OWIN = 2'd2;

`ifdef FPGA_FIRST_EN
    localparam logic [2:0] RESET_STATE = THINK;
    localparam logic       RESET_ARMED = 1'b1;
`else
    localparam logic [2:0] RESET_STATE = WAIT_USER;
    localparam logic       RESET_ARMED = 1'b0;
`endif

    logic [2:0]  state_reg;
    logic [17:0] board_reg;
    logic [17:0] board_next;
    logic [3:0]  move_reg;
    logic [3:0]  count_reg;
    logic        last_x_reg;
    logic        think_armed_reg;
    logic [1:0]  result_reg;
    logic        isdraw_reg;

    logic [15:0] empty_vec;
    logic        move_legal;
    logic [3:0]  low_sq;
    logic        owin;
    logic        xwin;
    logic        wr_en;
    logic [3:0]  wr_sq;
    logic [1:0]  wr_val;

    function automatic logic [1:0] sq(input logic [17:0] b, input int n);
        return b[19-2*n -: 2];
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] v);
        return ((sq(b,1) == v) && (sq(b,2) == v) && (sq(b,3) == v)) ||
               ((sq(b,4) == v) && (sq(b,5) == v) && (sq(b,6) == v)) ||
               ((sq(b,7) == v) && (sq(b,8) == v) && (sq(b,9) == v)) ||
               ((sq(b,1) == v) && (sq(b,4) == v) && (sq(b,7) == v)) ||
               ((sq(b,2) == v) && (sq(b,5) == v) && (sq(b,8) == v)) ||
               ((sq(b,3) == v) && (sq(b,6) == v) && (sq(b,9) == v)) ||
               ((sq(b,1) == v) && (sq(b,5) == v) && (sq(b,9) == v)) ||
               ((sq(b,3) == v) && (sq(b,5) == v) && (sq(b,7) == v));
    endfunction

    // empty_vec is indexed directly by a 4-bit move; codes 0 and 10..15 map to 0 (never legal)
    assign empty_vec[0]     = 1'b0;
    assign empty_vec[15:10] = 6'd0;

    genvar gi;
    generate
        for (gi = 1; gi <= 9; gi++) begin : g_square
            assign empty_vec[gi] = (board_reg[19-2*gi -: 2] == 2'b00);
            assign board_next[19-2*gi -: 2] = (wr_en && (wr_sq == 4'(gi))) ? wr_val
                                                                           : board_reg[19-2*gi -: 2];
        end
    endgenerate

    assign move_legal = empty_vec[move_reg];
    assign owin       = has_line(board_reg, CELL_O);
    assign xwin       = has_line(board_reg, CELL_X);

    always_comb begin
        low_sq = 4'd0;
        for (int i = 9; i >= 1; i--) begin
            if (empty_vec[i]) begin
                low_sq = 4'(i);
            end
        end
    end

    // An illegal engine reply is replaced by the lowest-numbered empty square
    always_comb begin
        wr_en  = 1'b0;
        wr_sq  = move_reg;
        wr_val = CELL_O;
        if (state_reg == CHK_USER) begin
            wr_en = move_legal;
        end else if (state_reg == CHK_FPGA) begin
            wr_en  = 1'b1;
            wr_val = CELL_X;
            wr_sq  = move_legal ? move_reg : low_sq;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= RESET_STATE;
            board_reg       <= 18'd0;
            move_reg        <= 4'd0;
            count_reg       <= 4'd0;
            last_x_reg      <= 1'b0;
            think_armed_reg <= RESET_ARMED;
            result_reg      <= RES_NONE;
            isdraw_reg      <= 1'b0;
        end else begin
            board_reg <= board_next;
            case (state_reg)
                WAIT_USER: begin
                    if (i_validmove_stb) begin
                        move_reg  <= i_move;
                        state_reg <= CHK_USER;
                    end
                end
                CHK_USER: begin
                    if (move_legal) begin
                        count_reg  <= count_reg + 4'd1;
                        last_x_reg <= 1'b0;
                        state_reg  <= EVAL;
                    end else begin
                        state_reg <= WAIT_USER;
                    end
                end
                EVAL: begin
                    // A completed line wins even on the ninth move
                    result_reg <= xwin ? RES_XWIN : (owin ? RES_OWIN : RES_NONE);
                    isdraw_reg <= !xwin && !owin && (count_reg == 4'd9);
                    state_reg  <= REPORT;
                end
                REPORT: begin
                    if ((result_reg != RES_NONE) || isdraw_reg) begin
                        state_reg <= OVER;
                    end else if (last_x_reg) begin
                        state_reg <= WAIT_USER;
                    end else begin
                        think_armed_reg <= 1'b1;
                        state_reg       <= THINK;
                    end
                end
                THINK: begin
                    think_armed_reg <= 1'b0;
                    if (i_fpga_move_stb) begin
                        move_reg  <= i_fpga_move;
                        state_reg <= CHK_FPGA;
                    end
                end
                CHK_FPGA: begin
                    count_reg  <= count_reg + 4'd1;
                    last_x_reg <= 1'b1;
                    state_reg  <= EVAL;
                end
                OVER: begin
                    state_reg <= OVER;
                end
                default: begin
                    state_reg <= WAIT_USER;
                end
            endcase
        end
    end

    // Level/strobe outputs are held low while reset is asserted
    assign o_needinput  = i_rst_n && (state_reg == WAIT_USER) && !i_busy;
    assign o_think_stb  = i_rst_n && (state_reg == THINK) && think_armed_reg;
    assign o_result_stb = (state_reg == REPORT);
    assign o_gameover   = (state_reg == OVER);
    assign o_board      = board_reg;
    assign o_result     = result_reg;
    assign o_isdraw     = isdraw_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl (default build, O moves first): a board model pushes expected
// result strobes into a queue; a monitor pops and compares them whenever o_result_stb fires.
module tb_game_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  i_move = 4'd0;
    logic        i_validmove_stb = 1'b0;
    logic        i_busy = 1'b0;
    logic        o_needinput;
    logic [17:0] o_board;
    logic [1:0]  o_result;
    logic        o_isdraw;
    logic        o_result_stb;
    logic        o_think_stb;
    logic [3:0]  i_fpga_move = 4'd0;
    logic        i_fpga_move_stb = 1'b0;
    logic        o_gameover;

    game_ctrl dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_move          (i_move),
        .i_validmove_stb (i_validmove_stb),
        .i_busy          (i_busy),
        .o_needinput     (o_needinput),
        .o_board         (o_board),
        .o_result        (o_result),
        .o_isdraw        (o_isdraw),
        .o_result_stb    (o_result_stb),
        .o_think_stb     (o_think_stb),
        .i_fpga_move     (i_fpga_move),
        .i_fpga_move_stb (i_fpga_move_stb),
        .o_gameover      (o_gameover)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] result;
        logic       isdraw;
    } res_t;

    int         checks_cnt = 0;
    int         errors_cnt = 0;
    res_t       exp_q[$];
    logic [1:0] mdl [1:9];
    int         mdl_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [17:0] mdl_board();
        logic [17:0] b;
        b = 18'd0;
        for (int n = 1; n <= 9; n++) b[19-2*n -: 2] = mdl[n];
        return b;
    endfunction

    function automatic bit mdl_line(input logic [1:0] v);
        int ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                          '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        for (int i = 0; i < 8; i++)
            if (mdl[ln[i][0]] == v && mdl[ln[i][1]] == v && mdl[ln[i][2]] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mdl_reset();
        for (int n = 1; n <= 9; n++) mdl[n] = 2'b00;
        mdl_count = 0;
        exp_q.delete();
    endtask

    task automatic mdl_place(input logic [1:0] v, input int s, output bit over);
        res_t r;
        mdl[s] = v;
        mdl_count++;
        r.result = mdl_line(2'b10) ? 2'd1 : (mdl_line(2'b01) ? 2'd2 : 2'd0);
        r.isdraw = (r.result == 2'd0) && (mdl_count == 9);
        over = (r.result != 2'd0) || r.isdraw;
        exp_q.push_back(r);
    endtask

    task automatic wait_ni();
        for (int i = 0; i < 20; i++) begin
            if (o_needinput === 1'b1) return;
            step();
        end
        check("needinput_timeout", 0, 1);
    endtask

    task automatic user_move(input int m, input bit busy);
        bit legal;
        bit over;
        legal = 1'b0;
        over  = 1'b0;
        if (m >= 1 && m <= 9) legal = (mdl[m] == 2'b00);
        if (busy) begin
            i_busy = 1'b1;
            #1;
            check("needinput_busy", o_needinput, 0);
        end else begin
            wait_ni();
        end
        $display("O move %0d legal=%0d", m, legal);
        i_move = 4'(m);
        i_validmove_stb = 1'b1;
        if (legal) mdl_place(2'b01, m, over);
        step();
        i_validmove_stb = 1'b0;
        i_busy = 1'b0;
        check("needinput_fall", o_needinput, 0);
        step();
        check("board_user", o_board, mdl_board());
        if (!legal) begin
            check("needinput_back", o_needinput, 1);
        end else begin
            step();
            check("result_stb_user", o_result_stb, 1);
            step();
            check("think_stb", o_think_stb, !over);
            check("gameover_user", o_gameover, over);
        end
    endtask

    task automatic engine_move(input int f);
        bit legal;
        bit over;
        int s;
        legal = 1'b0;
        if (f >= 1 && f <= 9) legal = (mdl[f] == 2'b00);
        s = f;
        if (!legal) begin
            s = 0;
            for (int n = 9; n >= 1; n--) if (mdl[n] == 2'b00) s = n;
        end
        $display("X move %0d placed %0d", f, s);
        i_fpga_move = 4'(f);
        i_fpga_move_stb = 1'b1;
        mdl_place(2'b10, s, over);
        step();
        i_fpga_move_stb = 1'b0;
        step();
        check("board_engine", o_board, mdl_board());
        step();
        check("result_stb_engine", o_result_stb, 1);
        step();
        if (over) check("gameover_engine", o_gameover, 1);
        else      check("needinput_engine", o_needinput, 1);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        mdl_reset();
        step();
    endtask

    // Scoreboard monitor: every result strobe must match the oldest expected entry
    initial begin
        res_t r;
        forever begin
            @(negedge i_clk);
            if (o_result_stb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("result_stb_unexpected", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("result", o_result, r.result);
                    check("isdraw", o_isdraw, r.isdraw);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int think_seen;
        logic [17:0] board_hold;
        mdl_reset();
        step();
        step();
        check("rst_board", o_board, 0);
        check("rst_needinput", o_needinput, 0);
        check("rst_result", o_result, 0);
        check("rst_isdraw", o_isdraw, 0);
        check("rst_result_stb", o_result_stb, 0);
        check("rst_think_stb", o_think_stb, 0);
        check("rst_gameover", o_gameover, 0);
        i_rst_n = 1'b1;
        step();
        check("idle_needinput", o_needinput, 1);

        // Game 1: illegal codes, illegal engine replies, occupied squares, stray engine strobe
        user_move(10, 0);
        user_move(0, 0);
        user_move(5, 0);
        engine_move(0);
        user_move(5, 0);
        user_move(1, 0);
        i_fpga_move = 4'd9;
        i_fpga_move_stb = 1'b1;
        step();
        i_fpga_move_stb = 1'b0;
        step();
        check("stray_engine_board", o_board, mdl_board());
        check("stray_engine_needinput", o_needinput, 1);
        user_move(2, 0);
        engine_move(2);
        user_move(7, 0);

        // Reset while in THINK, engine reply arrives during reset
        i_rst_n = 1'b0;
        #1;
        check("async_rst_board", o_board, 0);
        check("async_rst_think", o_think_stb, 0);
        step();
        i_fpga_move = 4'd4;
        i_fpga_move_stb = 1'b1;
        step();
        i_fpga_move_stb = 1'b0;
        i_rst_n = 1'b1;
        mdl_reset();
        think_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_think_stb === 1'b1) think_seen++;
        end
        check("post_rst_think_quiet", think_seen, 0);
        check("post_rst_board", o_board, 0);
        check("post_rst_needinput", o_needinput, 1);

        // Game 2: O wins on the top row, later strobes ignored
        user_move(1, 0);
        engine_move(4);
        user_move(2, 0);
        engine_move(5);
        user_move(3, 0);
        board_hold = o_board;
        i_move = 4'd7;
        i_validmove_stb = 1'b1;
        i_fpga_move = 4'd8;
        i_fpga_move_stb = 1'b1;
        step();
        i_validmove_stb = 1'b0;
        i_fpga_move_stb = 1'b0;
        step();
        step();
        step();
        check("over_board_hold", o_board, mdl_board());
        check("over_board_stable", o_board, board_hold);
        check("over_gameover", o_gameover, 1);
        check("over_needinput", o_needinput, 0);

        // Game 3: full board, no line -> draw (first move accepted while busy)
        do_reset();
        user_move(1, 1);
        engine_move(2);
        user_move(3, 0);
        engine_move(5);
        user_move(4, 0);
        engine_move(6);
        user_move(8, 0);
        engine_move(7);
        user_move(9, 0);

        // Game 4: ninth move completes a column -> OWIN, not a draw
        do_reset();
        user_move(1, 0);
        engine_move(2);
        user_move(6, 0);
        engine_move(4);
        user_move(8, 0);
        engine_move(5);
        user_move(3, 0);
        engine_move(7);
        user_move(9, 0);

        step();
        step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
